// File: rtl/text_display_lite_master.sv
// ---------------------------------------------------------------------------
// text_display_lite_master
//
// AXI4-Lite master that writes a run of C_NUM_TXN pattern words
// (address = C_BASE_ADDR + i*bytes, data = C_SEED + i) and, when the readback
// option is compiled in, reads the same words back and compares them.
// Exactly one write (or one read) is outstanding at any time.
//
// Compile-time option:
//   TDLM_READBACK_EN  defined   -> READ phase and data comparison present
//                     undefined -> WRITE goes straight to DONE, read channel
//                                  outputs tied to 0
//
// Ports:
//   ACLK, ARESETN        clock, synchronous active-low reset
//   INIT_AXI_TXN         rising edge starts a run (ignored while busy)
//   TXN_DONE             high from one cycle after DONE until the next run
//   ERROR                sticky: error response or readback mismatch
//   M_AXI_AW* / W* / B*  write address, write data, write response channels
//   M_AXI_AR* / R*       read address, read data channels
// ---------------------------------------------------------------------------
module text_display_lite_master #(
    parameter int                      C_ADDR_WIDTH = 32,
    parameter int                      C_DATA_WIDTH = 32,
    parameter int                      C_NUM_TXN    = 16,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = 32'h4000_0000,
    parameter logic [31:0]             C_SEED       = 32'hAA00_0000
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      INIT_AXI_TXN,
    output logic                      TXN_DONE,
    output logic                      ERROR,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int                      BYTES     = C_DATA_WIDTH / 8;
    localparam int                      IDX_W     = $clog2(C_NUM_TXN) + 1;
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(C_NUM_TXN - 1);
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP = C_ADDR_WIDTH'(BYTES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]              state;
    logic                    init_ff1;
    logic                    init_ff2;
    logic                    init_pulse;
    logic [IDX_W-1:0]        index;
    logic [C_ADDR_WIDTH-1:0] awaddr;
    logic                    awvalid;
    logic                    wvalid;
    logic                    bready;
    logic                    txn_done;
    logic                    error;
    logic [31:0]             pattern;

    // Pattern word for the current index; index only changes at a handshake
    // boundary, so WDATA is stable while WVALID waits on WREADY.
    assign pattern    = C_SEED + 32'(index);
    assign init_pulse = init_ff1 & ~init_ff2;

`ifdef TDLM_READBACK_EN
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic                    arvalid;
    logic                    rready;
    logic                    unused_resp;

    assign unused_resp = &{1'b0, M_AXI_BRESP[0], M_AXI_RRESP[0]};
`else
    logic                    unused_rd;

    assign unused_rd = &{1'b0, M_AXI_BRESP[0], M_AXI_ARREADY, M_AXI_RDATA,
                         M_AXI_RRESP, M_AXI_RVALID};
`endif

    // NOTE: reset is sampled only on the clock edge (synchronous); it is not in
    // the sensitivity list, and every register below is cleared in that branch.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state    <= ST_IDLE;
            // NOTE: the edge detector resets to 1 so an INIT level already high
            // when reset releases is not mistaken for a fresh rising edge.
            init_ff1 <= 1'b1;
            init_ff2 <= 1'b1;
            index    <= '0;
            awaddr   <= '0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            txn_done <= 1'b0;
            error    <= 1'b0;
`ifdef TDLM_READBACK_EN
            araddr   <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every read of a
            // register in this block sees its value from before the edge.
            init_ff1 <= INIT_AXI_TXN;
            init_ff2 <= init_ff1;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE) begin
                        txn_done <= 1'b1;
                    end
                    if (init_pulse) begin
                        // First AW/W pair goes out on entry to WRITE.
                        state    <= ST_WRITE;
                        error    <= 1'b0;
                        txn_done <= 1'b0;
                        index    <= '0;
                        awaddr   <= C_BASE_ADDR;
                        awvalid  <= 1'b1;
                        wvalid   <= 1'b1;
                        bready   <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (awvalid && M_AXI_AWREADY) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && M_AXI_WREADY) begin
                        wvalid <= 1'b0;
                    end
                    if (bready && M_AXI_BVALID) begin
                        bready <= 1'b0;
                        if (M_AXI_BRESP[1]) begin
                            error <= 1'b1;
                        end
                        if (index == LAST_IDX) begin
`ifdef TDLM_READBACK_EN
                            state   <= ST_READ;
                            index   <= '0;
                            araddr  <= C_BASE_ADDR;
                            arvalid <= 1'b1;
                            rready  <= 1'b1;
`else
                            state   <= ST_DONE;
`endif
                        end else begin
                            // Next pair issues directly behind the B handshake.
                            index   <= index + IDX_W'(1);
                            awaddr  <= awaddr + ADDR_STEP;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            bready  <= 1'b1;
                        end
                    end
                end

                ST_READ: begin
`ifdef TDLM_READBACK_EN
                    if (arvalid && M_AXI_ARREADY) begin
                        arvalid <= 1'b0;
                    end
                    if (rready && M_AXI_RVALID) begin
                        rready <= 1'b0;
                        if (M_AXI_RRESP[1] || (M_AXI_RDATA != C_DATA_WIDTH'(pattern))) begin
                            error <= 1'b1;
                        end
                        if (index == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            index   <= index + IDX_W'(1);
                            araddr  <= araddr + ADDR_STEP;
                            arvalid <= 1'b1;
                            rready  <= 1'b1;
                        end
                    end
`else
                    // Unreachable without readback; recover to IDLE.
                    state <= ST_IDLE;
`endif
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign TXN_DONE      = txn_done;
    assign ERROR         = error;
    assign M_AXI_AWADDR  = awaddr;
    assign M_AXI_AWVALID = awvalid;
    assign M_AXI_WDATA   = C_DATA_WIDTH'(pattern);
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid;
    assign M_AXI_BREADY  = bready;

`ifdef TDLM_READBACK_EN
    assign M_AXI_ARADDR  = araddr;
    assign M_AXI_ARVALID = arvalid;
    assign M_AXI_RREADY  = rready;
`else
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_text_display_lite_master.sv
// ---------------------------------------------------------------------------
// Testbench for text_display_lite_master.
// Main instance uses default parameters against a configurable AXI-Lite slave
// (ready stalls, error response injection, read-data corruption). A second
// instance with a base near the top of the address space checks wrap-around.
// ---------------------------------------------------------------------------
module tb_text_display_lite_master;

`ifdef TDLM_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int          N      = 16;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] SEED   = 32'hAA00_0000;
    localparam int          N2     = 4;
    localparam logic [31:0] BASE2  = 32'hFFFF_FFF8;
    localparam int          RD_N   = RB ? N : 0;
    localparam int          RD_N2  = RB ? N2 : 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // ---------------- main DUT ----------------
    logic        txn_done, error;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    text_display_lite_master dut (
        .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init),
        .TXN_DONE(txn_done), .ERROR(error),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // ---------------- slave model for the main DUT ----------------
    int aw_stall = 0, w_stall = 0, ar_stall = 0;
    int berr_word = -1, rbad_word = -1;
    int aw_wait, w_wait, ar_wait;
    int wr_count = 0, rd_count = 0, outstanding;
    int stab_viol = 0, order_viol = 0, bready_viol = 0;
    bit ar_seen = 0;
    logic have_aw, have_w;
    logic [31:0] cur_addr, cur_data;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] aw_log[$], w_log[$], ar_log[$];

    assign awready = (aw_wait >= aw_stall);
    assign wready  = (w_wait >= w_stall);
    assign arready = (ar_wait >= ar_stall);

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            have_aw <= 1'b0; have_w <= 1'b0; outstanding <= 0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            outstanding <= outstanding + ((awvalid && awready) ? 1 : 0) - ((bvalid && bready) ? 1 : 0);
            if (awvalid && awready) begin
                aw_log.push_back(awaddr);
                if (outstanding != 0) order_viol++;
                cur_addr <= awaddr;
                have_aw  <= 1'b1;
            end
            if (wvalid && wready) begin
                w_log.push_back(wdata);
                cur_data <= wdata;
                have_w   <= 1'b1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end else if (!bvalid && have_aw && have_w) begin
                bvalid  <= 1'b1;
                bresp   <= (wr_count == berr_word) ? 2'b10 : 2'b00;
                mem[cur_addr] = cur_data;
                wr_count++;
                have_aw <= 1'b0;
                have_w  <= 1'b0;
            end
            if (arvalid && arready) begin
                ar_log.push_back(araddr);
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= (rd_count == rbad_word) ? 32'h0 :
                          (mem.exists(araddr) ? mem[araddr] : 32'hDEAD_BEEF);
                rd_count++;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Protocol monitor: stability under back-pressure, BREADY coverage.
    bit p_aw = 0, p_w = 0, p_ar = 0;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    always @(posedge clk) begin
        if (!rst_n) begin
            p_aw = 0; p_w = 0; p_ar = 0;
        end else begin
            if (p_aw && (!awvalid || awaddr !== p_awaddr)) stab_viol++;
            if (p_w  && (!wvalid  || wdata  !== p_wdata))  stab_viol++;
            if (p_ar && (!arvalid || araddr !== p_araddr)) stab_viol++;
            if ((awvalid || wvalid) && !bready) bready_viol++;
            if (arvalid) ar_seen = 1;
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wdata  = wdata;
            p_ar = arvalid && !arready; p_araddr = araddr;
        end
    end

    // ---------------- wrap-around DUT ----------------
    logic        init2 = 1'b0;
    logic        txn_done2, error2;
    logic [31:0] awaddr2, wdata2, araddr2, rdata2;
    logic [3:0]  wstrb2;
    logic        awvalid2, wvalid2, bvalid2, bready2, arvalid2, rvalid2, rready2;
    logic        awready2 = 1'b1, wready2 = 1'b1, arready2 = 1'b1;
    logic [1:0]  bresp2 = 2'b00, rresp2 = 2'b00;
    logic [31:0] aw2_log[$], ar2_log[$];
    int          rd2_count = 0;

    text_display_lite_master #(.C_NUM_TXN(N2), .C_BASE_ADDR(BASE2)) dut2 (
        .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init2),
        .TXN_DONE(txn_done2), .ERROR(error2),
        .M_AXI_AWADDR(awaddr2), .M_AXI_AWVALID(awvalid2), .M_AXI_AWREADY(awready2),
        .M_AXI_WDATA(wdata2), .M_AXI_WSTRB(wstrb2), .M_AXI_WVALID(wvalid2), .M_AXI_WREADY(wready2),
        .M_AXI_BRESP(bresp2), .M_AXI_BVALID(bvalid2), .M_AXI_BREADY(bready2),
        .M_AXI_ARADDR(araddr2), .M_AXI_ARVALID(arvalid2), .M_AXI_ARREADY(arready2),
        .M_AXI_RDATA(rdata2), .M_AXI_RRESP(rresp2), .M_AXI_RVALID(rvalid2), .M_AXI_RREADY(rready2)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            bvalid2 <= 1'b0; rvalid2 <= 1'b0; rdata2 <= '0;
        end else begin
            if (awvalid2) aw2_log.push_back(awaddr2);
            if (bvalid2 && bready2) bvalid2 <= 1'b0;
            else if (wvalid2) bvalid2 <= 1'b1;
            if (arvalid2) begin
                ar2_log.push_back(araddr2);
                rvalid2 <= 1'b1;
                rdata2  <= SEED + 32'(rd2_count);
                rd2_count++;
            end else if (rvalid2 && rready2) begin
                rvalid2 <= 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    // Word i of a run carries value base + i*step (mod 2^32). Returns -1 when
    // the log matches, -2 on a length mismatch, else the first bad index.
    function automatic int list_bad(input logic [31:0] q[$], input logic [31:0] base,
                                    input logic [31:0] step, input int n);
        if (q.size() != n) return -2;
        for (int i = 0; i < n; i++) begin
            if (q[i] !== base + step * 32'(i)) return i;
        end
        return -1;
    endfunction

    function automatic bit exp_error();
        return (berr_word >= 0 && berr_word < N) || (RB && rbad_word >= 0 && rbad_word < N);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        aw_log.delete(); w_log.delete(); ar_log.delete();
        wr_count = 0; rd_count = 0; ar_seen = 0;
        stab_viol = 0; order_viol = 0; bready_viol = 0;
    endtask

    task automatic start_run();
        @(negedge clk);
        clear_logs();
        init = 1'b1;
        repeat (2) @(negedge clk);
        init = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (txn_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        init  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, txn_done, error} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000", {awvalid, wvalid, bready, arvalid, rready, txn_done, error});
        else passes++;
        checks++;
        if ({awaddr, araddr} !== 64'h0)
            $display("FAIL reset_addr: got awaddr=%h araddr=%h want 0", awaddr, araddr);
        else passes++;
        checks++;
        if (wstrb !== 4'hF) $display("FAIL wstrb: got %h want f", wstrb);
        else passes++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_checks(input string tag);
        bit ok;
        int bad;
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL %s_done: TXN_DONE never rose within 3000 cycles", tag);
        else passes++;
        bad = list_bad(aw_log, BASE, 32'd4, N);
        checks++;
        if (bad != -1) $display("FAIL %s_awaddr: code %0d, %0d writes seen, want %0d", tag, bad, aw_log.size(), N);
        else passes++;
        bad = list_bad(w_log, SEED, 32'd1, N);
        checks++;
        if (bad != -1) $display("FAIL %s_wdata: code %0d, %0d beats seen, want %0d", tag, bad, w_log.size(), N);
        else passes++;
        bad = list_bad(ar_log, BASE, 32'd4, RD_N);
        checks++;
        if (bad != -1 || ar_seen !== RB) $display("FAIL %s_araddr: code %0d, %0d reads seen, arvalid_seen=%0d, want %0d reads", tag, bad, ar_log.size(), ar_seen, RD_N);
        else passes++;
        checks++;
        if (error !== exp_error()) $display("FAIL %s_error: got %b want %b", tag, error, exp_error());
        else passes++;
        checks++;
        if (stab_viol != 0 || order_viol != 0 || bready_viol != 0)
            $display("FAIL %s_protocol: stability=%0d overlap=%0d bready=%0d want all 0", tag, stab_viol, order_viol, bready_viol);
        else passes++;
    endtask

    task automatic test_basic();
        aw_stall = 0; w_stall = 0; ar_stall = 0; berr_word = -1; rbad_word = -1;
        start_run();
        run_checks("basic");
        repeat (5) @(negedge clk);
        checks++;
        if (txn_done !== 1'b1) $display("FAIL done_hold: got %b want 1", txn_done);
        else passes++;
    endtask

    task automatic test_stalls();
        aw_stall = 5; w_stall = 2; ar_stall = 3; berr_word = -1; rbad_word = -1;
        start_run();
        run_checks("stall");
    endtask

    task automatic test_bresp_error();
        aw_stall = 0; w_stall = 0; ar_stall = 0; berr_word = 3; rbad_word = -1;
        start_run();
        run_checks("bresp");
        berr_word = -1;
        start_run();
        repeat (3) @(negedge clk);
        checks++;
        if ({error, txn_done} !== 2'b00) $display("FAIL error_clear: got error=%b done=%b want 0 0", error, txn_done);
        else passes++;
        run_checks("after_err");
    endtask

    task automatic test_rdata_corrupt();
        aw_stall = 1; w_stall = 0; ar_stall = 0; berr_word = -1; rbad_word = 7;
        start_run();
        run_checks("rcorrupt");
        rbad_word = -1;
    endtask

    task automatic test_back_to_back();
        // A second INIT edge while busy must not restart the run.
        aw_stall = 2; w_stall = 1; ar_stall = 1; berr_word = -1; rbad_word = -1;
        start_run();
        repeat (10) @(negedge clk);
        init = 1'b1;
        repeat (2) @(negedge clk);
        init = 1'b0;
        run_checks("busy_init");
    endtask

    task automatic test_reset_mid_run();
        bit reached = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0; berr_word = -1; rbad_word = -1;
        @(negedge clk);
        clear_logs();
        init = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (aw_log.size() >= 6) begin reached = 1; break; end
        end
        checks++;
        if (!reached) $display("FAIL midrun_reach: only %0d writes seen, want 6", aw_log.size());
        else passes++;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, txn_done, error} !== 7'b0 || {awaddr, araddr} !== 64'h0)
            $display("FAIL midrun_reset: got ctrl=%b awaddr=%h araddr=%h want 0", {awvalid, wvalid, bready, arvalid, rready, txn_done, error}, awaddr, araddr);
        else passes++;
        rst_n = 1'b1;
        clear_logs();
        repeat (20) @(negedge clk);
        checks++;
        if (aw_log.size() != 0 || awvalid !== 1'b0 || txn_done !== 1'b0)
            $display("FAIL midrun_no_start: writes=%0d awvalid=%b done=%b want 0 0 0", aw_log.size(), awvalid, txn_done);
        else passes++;
        init = 1'b0;
        repeat (3) @(negedge clk);
        start_run();
        run_checks("post_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            aw_stall  = $urandom_range(0, 4);
            w_stall   = $urandom_range(0, 4);
            ar_stall  = $urandom_range(0, 4);
            berr_word = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            rbad_word = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            start_run();
            run_checks($sformatf("rand%0d", r));
        end
        berr_word = -1; rbad_word = -1;
    endtask

    task automatic test_addr_wrap();
        bit ok = 0;
        int bad;
        aw2_log.delete(); ar2_log.delete(); rd2_count = 0;
        @(negedge clk);
        init2 = 1'b1;
        repeat (2) @(negedge clk);
        init2 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (txn_done2 === 1'b1) begin ok = 1; break; end
        end
        checks++;
        if (!ok) $display("FAIL wrap_done: TXN_DONE never rose within 1000 cycles");
        else passes++;
        bad = list_bad(aw2_log, BASE2, 32'd4, N2);
        checks++;
        if (bad != -1) $display("FAIL wrap_awaddr: code %0d, first addr %h, %0d writes, want %0d", bad, (aw2_log.size() > 0) ? aw2_log[0] : 32'h0, aw2_log.size(), N2);
        else passes++;
        bad = list_bad(ar2_log, BASE2, 32'd4, RD_N2);
        checks++;
        if (bad != -1 || error2 !== 1'b0) $display("FAIL wrap_read: code %0d, %0d reads, error=%b want %0d reads error 0", bad, ar2_log.size(), error2, RD_N2);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_bresp_error();
        test_rdata_corrupt();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_addr_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

endmodule
